// File: rtl/counter_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// counter_sequencer_pkg
//   Shared definitions for the counter sequencer and its prescaler:
//   command opcodes, FSM state encodings and default widths.
//   No ports (package).
// -----------------------------------------------------------------------------
package counter_sequencer_pkg;

    // Default widths used when the blocks are instantiated without overrides.
    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE_W = 4;

    // Command opcodes carried on CMD_OP.
    typedef enum logic [1:0] {
        OP_STOP = 2'b00,
        OP_LOAD = 2'b01,
        OP_RUN  = 2'b10,
        OP_STEP = 2'b11
    } cmd_op_e;

    // Sequencer FSM states. The encoding is exported on STATE_DBG.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Command port readiness: always ready outside RUN; inside RUN a command
    // is taken only in a prescaler tick cycle.
    function automatic logic cmd_ready_for(input state_e state, input logic tick);
        return (state != ST_RUN) || tick;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
//   Free-running PRESCALE_W-bit divider that produces one tick every
//   (divisor + 1) enabled cycles. The divisor is captured into a local
//   register when load_i is asserted so it stays stable for a whole run.
//
// Ports
//   CLK      in   1           clock, rising edge
//   RSTdash  in   1           asynchronous active-low reset
//   clr_i    in   1           clear the prescale counter to zero
//   load_i   in   1           capture div_i into the divisor register
//   en_i     in   1           count enable (sequencer is in RUN)
//   div_i    in   PRESCALE_W  divisor to capture on load_i
//   tick_o   out  1           high while enabled and counter == divisor
// -----------------------------------------------------------------------------
module counter_prescaler
    import counter_sequencer_pkg::*;
#(
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RSTdash,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] div_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_d;
    logic [PRESCALE_W-1:0] div_q;
    logic [PRESCALE_W-1:0] div_d;

    // The tick is a decode of registered state, so it is valid for the whole
    // cycle and can be used combinationally for command readiness.
    assign tick_o = en_i && (pre_q == div_q);

    always_comb begin
        pre_d = pre_q;
        div_d = div_q;

        if (load_i) begin
            div_d = div_i;
        end

        // A clear always wins over counting, so the first tick after a clear
        // comes exactly (divisor + 1) enabled cycles later.
        if (clr_i) begin
            pre_d = '0;
        end else if (en_i) begin
            if (tick_o) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTdash) begin
        if (!RSTdash) begin
            pre_q <= '0;
            div_q <= '0;
        end else begin
            pre_q <= pre_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//   Command-driven controller for a WIDTH-bit up/down counter. A host issues
//   STOP / LOAD / RUN / STEP over a valid/ready port; while running, the count
//   moves by one on every prescaler tick (every DIV+1 cycles). Reaching the
//   terminal value LIMIT by counting raises a one-cycle TC pulse and either
//   halts (WRAP=0) or reloads the last LOADed value on the next tick (WRAP=1).
//
// Handshake
//   A command transfers on a rising CLK edge where CMD_VALID && CMD_READY.
//   CMD_READY does not depend on CMD_VALID. The host must hold CMD_OP and its
//   operands stable while CMD_VALID is high and not yet accepted.
//
// Ports
//   CLK        in   1           clock, all state updates on rising edge
//   RSTdash    in   1           asynchronous active-low reset
//   CMD_VALID  in   1           command present
//   CMD_READY  out  1           command will be taken at the next edge
//   CMD_OP     in   2           00 STOP, 01 LOAD, 10 RUN, 11 STEP
//   CMD_DATA   in   WIDTH       LOAD value
//   LIMIT      in   WIDTH       terminal value, captured on RUN accept
//   DIV        in   PRESCALE_W  prescale divisor, captured on RUN accept
//   UP         in   1           count direction, captured on RUN accept
//   COUNT      out  WIDTH       registered count
//   RUNNING    out  1           high while in RUN
//   TC         out  1           one-cycle pulse when COUNT first shows LIMIT
//   STATE_DBG  out  2           current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W,
    parameter bit WRAP       = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RSTdash,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_OP,
    input  logic [WIDTH-1:0]      CMD_DATA,
    input  logic [WIDTH-1:0]      LIMIT,
    input  logic [PRESCALE_W-1:0] DIV,
    input  logic                  UP,
    output logic [WIDTH-1:0]      COUNT,
    output logic                  RUNNING,
    output logic                  TC,
    output state_e                STATE_DBG
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] limit_q,  limit_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             up_q,     up_d;
    logic             tc_q,     tc_d;

    logic             tick;
    logic             cmd_accept;
    cmd_op_e          cmd_op;
    logic             pre_clr;
    logic             div_load;
    logic [WIDTH-1:0] next_val;

    // One step in the captured direction; arithmetic wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] value,
                                                    input logic             up);
        if (up) begin
            return value + WIDTH'(1);
        end
        return value - WIDTH'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Prescaler
    // -------------------------------------------------------------------------
    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .CLK     (CLK),
        .RSTdash (RSTdash),
        .clr_i   (pre_clr),
        .load_i  (div_load),
        .en_i    (state_q == ST_RUN),
        .div_i   (DIV),
        .tick_o  (tick)
    );

    // -------------------------------------------------------------------------
    // Command port
    // -------------------------------------------------------------------------
    assign cmd_op     = cmd_op_e'(CMD_OP);
    assign CMD_READY  = cmd_ready_for(state_q, tick);
    assign cmd_accept = CMD_VALID && CMD_READY;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        up_d     = up_q;
        tc_d     = 1'b0;
        pre_clr  = 1'b0;
        div_load = 1'b0;
        next_val = step_count(count_q, up_q);

        if (cmd_accept) begin
            // In RUN a command can only be accepted in a tick cycle; the
            // command takes priority and that tick's count update is dropped.
            case (cmd_op)
                OP_STOP: begin
                    state_d = ST_IDLE;
                end
                OP_LOAD: begin
                    count_d  = CMD_DATA;
                    reload_d = CMD_DATA;
                    pre_clr  = 1'b1;
                    if (state_q == ST_DONE) begin
                        state_d = ST_IDLE;
                    end
                end
                OP_RUN: begin
                    // COUNT is left alone: restarting from DONE begins at
                    // LIMIT and must run the full modulus before TC again.
                    limit_d  = LIMIT;
                    up_d     = UP;
                    div_load = 1'b1;
                    pre_clr  = 1'b1;
                    state_d  = ST_RUN;
                end
                OP_STEP: begin
                    // Single manual step outside RUN; ignored while running.
                    if (state_q != ST_RUN) begin
                        count_d = next_val;
                        tc_d    = (next_val == limit_q);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (tick) begin
            // tick only asserts in RUN.
            if (WRAP && (count_q == limit_q)) begin
                // Reload is not a count step, so it never raises TC.
                count_d = reload_q;
            end else begin
                count_d = next_val;
                if (next_val == limit_q) begin
                    tc_d = 1'b1;
                    if (!WRAP) begin
                        state_d = ST_DONE;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTdash) begin
        if (!RSTdash) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            limit_q  <= '1;
            reload_q <= '0;
            up_q     <= 1'b1;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            up_q     <= up_d;
            tc_q     <= tc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign COUNT     = count_q;
    assign TC        = tc_q;
    assign RUNNING   = (state_q == ST_RUN);
    assign STATE_DBG = state_q;

endmodule
